// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state encoding and helpers for rr_arbiter_8
package arb_pkg;

  localparam int ARB_N    = 8;
  localparam int ARB_IDXW = 3;

  localparam logic [ARB_IDXW-1:0] ARB_PTR_RST = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  function automatic logic [ARB_N-1:0] idx_to_onehot(input logic [ARB_IDXW-1:0] idx);
    logic [ARB_N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder; search starts just after ptr
module rr_pick
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]    req,
  input  logic [ARB_IDXW-1:0] ptr,
  input  logic [ARB_IDXW-1:0] mask_idx,
  input  logic                mask_en,
  output logic [ARB_IDXW-1:0] win_idx,
  output logic                win_valid
);

  logic [ARB_N-1:0]    masked;
  logic [ARB_IDXW-1:0] cand;

  always_comb begin
    masked = req;
    if (mask_en) masked[mask_idx] = 1'b0;
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    // k = 8 wraps back to ptr itself, which therefore has the lowest priority
    for (int k = 1; k <= ARB_N; k++) begin
      cand = ptr + ARB_IDXW'(k);
      if (!win_valid && masked[cand]) begin
        win_idx   = cand;
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with held grants; HOLD_TIMEOUT_EN adds a forced-release timer
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int IDXW = ARB_IDXW
`ifdef HOLD_TIMEOUT_EN
  ,
  parameter int MAX_HOLD = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_valid,
  output logic            timeout
);

  arb_state_t          state;
  logic [IDXW-1:0]     ptr;
  logic [IDXW-1:0]     win_idx;
  logic                win_valid;
  logic                force_rel;
  logic                rel;
  logic                new_grant;

  // While granted, re-arbitrate as if the current grantee were the last winner.
  rr_pick u_pick (
    .req       (req),
    .ptr       ((state == ST_GRANT) ? gnt_idx : ptr),
    .mask_idx  (gnt_idx),
    .mask_en   (state == ST_GRANT),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign rel       = done || !req[gnt_idx] || force_rel;
  assign new_grant = win_valid && ((state == ST_IDLE) || rel);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      ptr       <= ARB_PTR_RST;
    end else begin
      if (state == ST_GRANT && rel) ptr <= gnt_idx;
      if (new_grant) begin
        gnt       <= idx_to_onehot(win_idx);
        gnt_idx   <= win_idx;
        gnt_valid <= 1'b1;
        state     <= ST_GRANT;
      end else if (state == ST_GRANT && rel) begin
        gnt       <= '0;
        gnt_idx   <= '0;
        gnt_valid <= 1'b0;
        state     <= ST_IDLE;
      end
    end
  end

`ifdef HOLD_TIMEOUT_EN
  logic [4:0] hold_cnt;

  assign force_rel = (state == ST_GRANT) && (hold_cnt == 5'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (new_grant)               hold_cnt <= '0;
      else if (state == ST_GRANT)  hold_cnt <= hold_cnt + 5'd1;
      // a natural release on the same cycle takes precedence over the timer
      timeout <= force_rel && !done && req[gnt_idx];
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - scoreboard bench for rr_arbiter_8 with directed vectors
module tb_rr_arbiter_8;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  string name_q[$];

  rr_arbiter_8 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
    end
  endtask

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic [7:0] r, input logic d,
                      input logic [7:0] eg, input logic [2:0] ei, input logic ev);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back('{gnt: eg, idx: ei, valid: ev});
    name_q.push_back(nm);
  endtask

  // Monitor: compares registered outputs just after each edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("valid_eq_or_gnt", 32'(gnt_valid), 32'(|gnt));
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    end
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check({n, "_gnt"}, 32'(gnt), 32'(e.gnt));
      check({n, "_idx"}, 32'(gnt_idx), 32'(e.idx));
      check({n, "_valid"}, 32'(gnt_valid), 32'(e.valid));
      check({n, "_timeout"}, 32'(timeout), 32'd0);
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_idx", 32'(gnt_idx), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // single requester, 1-cycle latency, then async reset mid-grant
    step("single", 8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
    step("single_hold", 8'h04, 1'b0, 8'h04, 3'd2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'd0);
    check("async_rst_valid", 32'(gnt_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    step("idle", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // all requesting, done every grant: 0..7,0 back-to-back
    step("rr_0", 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      logic [2:0] ei;
      ei = 3'(i % 8);
      step($sformatf("rr_%0d", i), 8'hFF, 1'b1, 8'(1 << ei), ei, 1'b1);
    end
    step("rr_end", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    // wrap from ptr=5 to idx 0, then back to 5
    step("wrap_g5", 8'h20, 1'b0, 8'h20, 3'd5, 1'b1);
    step("wrap_g0", 8'h21, 1'b1, 8'h01, 3'd0, 1'b1);
    step("wrap_hold0", 8'h21, 1'b0, 8'h01, 3'd0, 1'b1);
    step("wrap_back5", 8'h21, 1'b1, 8'h20, 3'd5, 1'b1);
    step("wrap_idle", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    // grantee drops request, goes idle, regranted after one cycle
    step("drop_g3", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
    step("drop_idle", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);
    step("drop_reg3", 8'h08, 1'b0, 8'h08, 3'd3, 1'b1);
    step("drop_idle2", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // non-grantee toggling has no effect until release
    step("tog_g0", 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    step("tog_a", 8'h03, 1'b0, 8'h01, 3'd0, 1'b1);
    step("tog_b", 8'h01, 1'b0, 8'h01, 3'd0, 1'b1);
    step("tog_c", 8'h03, 1'b0, 8'h01, 3'd0, 1'b1);
    step("tog_rel", 8'h03, 1'b1, 8'h02, 3'd1, 1'b1);
    step("tog_idle", 8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // done while idle is ignored
    step("done_idle", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);

    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
